// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic countdown display: segment glyphs,
// conversion state encoding and small helpers used by the BCD engine.
package traffic_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_ALL   = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } conv_state_e;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = SEG_0;
            4'd1:    g = SEG_1;
            4'd2:    g = SEG_2;
            4'd3:    g = SEG_3;
            4'd4:    g = SEG_4;
            4'd5:    g = SEG_5;
            4'd6:    g = SEG_6;
            4'd7:    g = SEG_7;
            4'd8:    g = SEG_8;
            4'd9:    g = SEG_9;
            default: g = SEG_BLANK;
        endcase
        return g;
    endfunction

    // Double-dabble correction: a nibble of 5 or more would overflow past 9 after the shift.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter. Re-converts whenever the
// input differs from the last value it converted, and latches the result.
module bin2bcd_seq
    import traffic_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       ovf,
    output logic       busy
);

    conv_state_e state_q, state_d;
    logic [7:0]  cap_q, cap_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  iter_q, iter_d;
    logic [7:0]  last_q, last_d;
    logic [3:0]  bcd_tens_q, bcd_tens_d;
    logic [3:0]  bcd_units_q, bcd_units_d;
    logic        ovf_q, ovf_d;
    logic        busy_q, busy_d;
    logic [11:0] adj;

    always_comb begin
        state_d     = state_q;
        cap_d       = cap_q;
        scratch_d   = scratch_q;
        iter_d      = iter_q;
        last_d      = last_q;
        bcd_tens_d  = bcd_tens_q;
        bcd_units_d = bcd_units_q;
        ovf_d       = ovf_q;
        adj         = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};

        case (state_q)
            IDLE: begin
                if (count != last_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cap_d     = count;
                last_d    = count;
                scratch_d = '0;
                iter_d    = '0;
                state_d   = SHIFT;
            end
            SHIFT: begin
                {scratch_d, cap_d} = {adj, cap_q} << 1;
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_tens_d  = scratch_q[7:4];
                bcd_units_d = scratch_q[3:0];
                ovf_d       = (scratch_q[11:8] != 4'd0);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_q       <= '0;
            scratch_q   <= '0;
            iter_q      <= '0;
            last_q      <= '0;
            bcd_tens_q  <= '0;
            bcd_units_q <= '0;
            ovf_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_q       <= cap_d;
            scratch_q   <= scratch_d;
            iter_q      <= iter_d;
            last_q      <= last_d;
            bcd_tens_q  <= bcd_tens_d;
            bcd_units_q <= bcd_units_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign bcd_tens  = bcd_tens_q;
    assign bcd_units = bcd_units_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: rtl/traffic_countdown_display.sv
// Two-digit multiplexed 7-segment display of the controller countdown,
// with lamp-test / lamp-off / flash overrides on the panel inputs.
module traffic_countdown_display
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] count,
    input  logic       clr,
    input  logic       test,
    input  logic       flicker,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_units,
    output logic       ovf,
    output logic       busy
);

    localparam logic [7:0] SCAN_LAST = 8'(SCAN_DIV - 1);

    logic [7:0] scan_cnt_q, scan_cnt_d;
    logic [1:0] an_q, an_d;
    logic [6:0] seg_q, seg_d;

    bin2bcd_seq u_bcd (
        .clk       (clk),
        .rst       (rst),
        .count     (count),
        .bcd_tens  (bcd_tens),
        .bcd_units (bcd_units),
        .ovf       (ovf),
        .busy      (busy)
    );

    // The glyph follows the next digit enable so seg and an always switch together.
    always_comb begin
        scan_cnt_d = scan_cnt_q + 8'd1;
        an_d       = an_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            an_d       = ~an_q;
        end

        if (!test) begin
            seg_d = SEG_ALL;
        end else if (!clr || flicker) begin
            seg_d = SEG_BLANK;
        end else if (ovf) begin
            seg_d = SEG_DASH;
        end else if (an_d[1]) begin
            seg_d = (bcd_tens == 4'd0) ? SEG_BLANK : digit_glyph(bcd_tens);
        end else begin
            seg_d = digit_glyph(bcd_units);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_q <= '0;
            an_q       <= 2'b01;
            seg_q      <= SEG_BLANK;
        end else begin
            scan_cnt_q <= scan_cnt_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
